// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback stage: op codes, FSM encoding,
// default datapath geometry.
package alu_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int RA_W_DEF  = 2;

    localparam logic [1:0] OP_ZERO = 2'd0;
    localparam logic [1:0] OP_ONE  = 2'd1;
    localparam logic [1:0] OP_OR   = 2'd2;
    localparam logic [1:0] OP_AND  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issue_rf_if.sv
// Command handshake and writeback result bundle between a command source and
// the ALU issue stage.
interface alu_issue_rf_if #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 2
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [RA_W-1:0] cmd_src_a;
    logic [RA_W-1:0] cmd_src_b;
    logic [RA_W-1:0] cmd_dst;

    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic [RA_W-1:0]  res_dst;

    modport master (
        output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst,
        input  cmd_ready, res_valid, res_data, res_dst
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst,
        output cmd_ready, res_valid, res_data, res_dst
    );
endinterface

// File: rtl/alu_regfile.sv
// Small register file: three combinational read ports, a writeback port and a
// direct-load port, with writeback taking priority on an address collision.
module alu_regfile #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RA_W-1:0]  ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [RA_W-1:0]  rb_addr,
    output logic [WIDTH-1:0] rb_data,
    input  logic [RA_W-1:0]  dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    input  logic             wb_en,
    input  logic [RA_W-1:0]  wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             ld_en,
    input  logic [RA_W-1:0]  ld_addr,
    input  logic [WIDTH-1:0] ld_data
);
    localparam int NREG = 1 << RA_W;

    logic [WIDTH-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                // A load colliding with writeback is dropped.
                if (wb_en && wb_addr == RA_W'(i))
                    regs[i] <= wb_data;
                else if (ld_en && ld_addr == RA_W'(i))
                    regs[i] <= ld_data;
            end
        end
    end

    assign ra_data  = regs[ra_addr];
    assign rb_data  = regs[rb_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_rf.sv
// Operand-issue / writeback stage feeding an external combinational ALU.
// One command in flight: IDLE -> EXEC -> WB, three cycles per command.
module alu_issue_rf
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RA_W  = RA_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_rf_if.slave    cmd,
    input  logic             ld_valid,
    input  logic [RA_W-1:0]  ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [RA_W-1:0]  rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       Upr_ALU,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Out_ALU
);
    state_e           state, nstate;
    logic             ready, wb_en, accept;
    logic [RA_W-1:0]  dst_q;
    logic [WIDTH-1:0] ra_data, rb_data;
    logic [WIDTH-1:0] res_data_q;
    logic [RA_W-1:0]  res_dst_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        ready  = 1'b0;
        wb_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (cmd.cmd_valid) nstate = ST_EXEC;
            end
            ST_EXEC: nstate = ST_WB;
            ST_WB: begin
                wb_en  = 1'b1;
                nstate = ST_IDLE;
            end
            default: nstate = ST_IDLE;
        endcase
    end

    assign accept = cmd.cmd_valid && ready;

    // Operands come straight off the read ports, so a same-edge load is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Upr_ALU <= OP_ZERO;
            A       <= '0;
            B       <= '0;
            dst_q   <= '0;
        end else if (accept) begin
            Upr_ALU <= cmd.cmd_op;
            A       <= ra_data;
            B       <= rb_data;
            dst_q   <= cmd.cmd_dst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data_q <= '0;
            res_dst_q  <= '0;
        end else if (state == ST_EXEC) begin
            res_data_q <= Out_ALU;
            res_dst_q  <= dst_q;
        end
    end

    assign cmd.cmd_ready = ready;
    assign cmd.res_valid = wb_en;
    assign cmd.res_data  = res_data_q;
    assign cmd.res_dst   = res_dst_q;

    alu_regfile #(.WIDTH(WIDTH), .RA_W(RA_W)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra_addr  (cmd.cmd_src_a),
        .ra_data  (ra_data),
        .rb_addr  (cmd.cmd_src_b),
        .rb_data  (rb_data),
        .dbg_addr (rd_addr),
        .dbg_data (rd_data),
        .wb_en    (wb_en),
        .wb_addr  (res_dst_q),
        .wb_data  (res_data_q),
        .ld_en    (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

endmodule

// File: tb/tb_alu_issue_rf.sv
// Scoreboard bench for alu_issue_rf with a behavioural ALU alongside the DUT.
module tb_alu_issue_rf;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int RA_W  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ld_valid;
    logic [RA_W-1:0]  ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic [RA_W-1:0]  rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [1:0]       Upr_ALU;
    logic [WIDTH-1:0] A, B, Out_ALU;

    always #5 clk = ~clk;

    alu_issue_rf_if #(.WIDTH(WIDTH), .RA_W(RA_W)) bus ();

    alu_issue_rf #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (bus.slave),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .Upr_ALU  (Upr_ALU),
        .A        (A),
        .B        (B),
        .Out_ALU  (Out_ALU)
    );

    // Reference ALU placed beside the stage
    always_comb begin
        case (Upr_ALU)
            OP_ZERO: Out_ALU = '0;
            OP_ONE:  Out_ALU = 32'd1;
            OP_OR:   Out_ALU = A | B;
            default: Out_ALU = A & B;
        endcase
    end

    typedef struct {
        logic [31:0] data;
        logic [1:0]  dst;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.res_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_res: got res_valid with dst %0d data 0x%08h, expected none",
                         bus.res_dst, bus.res_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_data", bus.res_data, e.data);
                chk("res_dst", 32'(bus.res_dst), 32'(e.dst));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] addr, input logic [31:0] exp);
        rd_addr = addr;
        #1;
        chk(name, rd_data, exp);
    endtask

    task automatic load(input logic [1:0] addr, input logic [31:0] data);
        ld_valid = 1'b1;
        ld_addr  = addr;
        ld_data  = data;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic set_cmd(input logic [1:0] op, input logic [1:0] sa, input logic [1:0] sb_a,
                           input logic [1:0] d);
        bus.cmd_op    = op;
        bus.cmd_src_a = sa;
        bus.cmd_src_b = sb_a;
        bus.cmd_dst   = d;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] sa, input logic [1:0] sbr,
                         input logic [1:0] d, input logic [31:0] exp);
        set_cmd(op, sa, sbr, d);
        bus.cmd_valid = 1'b1;
        sb.push_back('{exp, d});
        tick();
        bus.cmd_valid = 1'b0;
        chk("upr_alu_e0", 32'(Upr_ALU), 32'(op));
        chk("ready_exec", 32'(bus.cmd_ready), 32'd0);
        tick();
        tick();
        rd_chk("rf_after_wb", d, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc[$];
        int busy;

        bus.cmd_valid = 1'b0;
        set_cmd(2'd0, 2'd0, 2'd0, 2'd0);
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        rd_addr  = '0;

        #12 rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) rd_chk("reset_rf", 2'(i), 32'd0);
        chk("reset_ready", 32'(bus.cmd_ready), 32'd1);
        chk("reset_res_valid", 32'(bus.res_valid), 32'd0);
        chk("reset_upr", 32'(Upr_ALU), 32'd0);
        chk("reset_A", A, 32'd0);
        chk("reset_B", B, 32'd0);

        tick();
        load(2'd1, 32'hF0F0_0000);
        load(2'd2, 32'h0FF0_00FF);
        rd_chk("load_r1", 2'd1, 32'hF0F0_0000);

        issue(OP_OR,   2'd1, 2'd2, 2'd3, 32'hFFF0_00FF);
        issue(OP_AND,  2'd1, 2'd2, 2'd0, 32'h00F0_0000);
        issue(OP_ZERO, 2'd1, 2'd2, 2'd1, 32'h0000_0000);
        issue(OP_ONE,  2'd1, 2'd2, 2'd2, 32'h0000_0001);

        load(2'd1, 32'hF0F0_0000);
        load(2'd2, 32'h0FF0_00FF);

        // Held cmd_valid: acceptance only when IDLE
        busy = 0;
        set_cmd(OP_OR, 2'd1, 2'd2, 2'd3);
        bus.cmd_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (bus.cmd_ready) begin
                acc_cyc.push_back(c);
                sb.push_back('{32'hFFF0_00FF, 2'd3});
            end else begin
                busy++;
            end
            tick();
        end
        bus.cmd_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_cyc.size()), 32'd3);
        chk("b2b_busy_cycles", 32'(busy), 32'd6);
        if (acc_cyc.size() >= 3) begin
            chk("b2b_spacing1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            chk("b2b_spacing2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end
        rd_chk("b2b_r3", 2'd3, 32'hFFF0_00FF);

        // Load on the WB edge to the writeback destination loses
        set_cmd(OP_AND, 2'd1, 2'd2, 2'd3);
        bus.cmd_valid = 1'b1;
        sb.push_back('{32'h00F0_0000, 2'd3});
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        ld_valid = 1'b1;
        ld_addr  = 2'd3;
        ld_data  = 32'hDEAD_BEEF;
        tick();
        ld_valid = 1'b0;
        rd_chk("wb_beats_load", 2'd3, 32'h00F0_0000);

        // Load to a source during EXEC leaves the in-flight result alone
        set_cmd(OP_OR, 2'd1, 2'd2, 2'd0);
        bus.cmd_valid = 1'b1;
        sb.push_back('{32'hFFF0_00FF, 2'd0});
        tick();
        bus.cmd_valid = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 2'd1;
        ld_data  = 32'h0;
        tick();
        ld_valid = 1'b0;
        tick();
        rd_chk("exec_load_r0", 2'd0, 32'hFFF0_00FF);
        rd_chk("exec_load_r1", 2'd1, 32'h0);

        // Reset during EXEC aborts the command
        set_cmd(OP_ONE, 2'd0, 2'd0, 2'd2);
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        chk("abort_in_exec", 32'(bus.cmd_ready), 32'd0);
        #2 rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
        chk("abort_res_valid", 32'(bus.res_valid), 32'd0);
        rd_chk("abort_dst", 2'd2, 32'd0);
        tick();
        tick();
        tick();

        issue(OP_ONE, 2'd0, 2'd0, 2'd1, 32'h0000_0001);

        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_issue_rf.md
# alu_issue_rf

Operand-issue and writeback stage that sits directly upstream of the 32-bit combinational ALU (op 0 = zero, 1 = one, 2 = OR, 3 = AND).
- Holds a small register file and accepts ALU commands over a valid/ready handshake.
- Drives the ALU's `Upr_ALU`/`A`/`B` inputs from registered operands, captures `Out_ALU`, and writes the result back to a destination register.
- One command in flight at a time; fixed 3-cycle occupancy.

## Interface
- `WIDTH`, 32: datapath width; must match the ALU.
- `RA_W`, 2: register address width; register count = 2^RA_W.

- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  stage can accept a command.
- `cmd_op`  in  2  ALU op code, same encoding as `Upr_ALU`.
- `cmd_src_a`, `cmd_src_b`, `cmd_dst`  in  RA_W each  operand A, operand B, and destination register.
- `ld_valid`  in  1  direct register load strobe.
- `ld_addr`  in  RA_W  load address.
- `ld_data`  in  WIDTH  load data.
- `rd_addr`  in  RA_W  debug read address.
- `rd_data`  out  WIDTH  combinational read of `regs[rd_addr]`.
- `Upr_ALU`  out  2  registered op to the ALU.
- `A`, `B`  out  WIDTH  registered operands to the ALU.
- `Out_ALU`  in  WIDTH  ALU result (combinational from `Upr_ALU`/`A`/`B`).
- `res_valid`  out  1  one-cycle writeback pulse.
- `res_data`  out  WIDTH  captured result.
- `res_dst`  out  RA_W  captured destination.

## Operation
- FSM states: IDLE, EXEC, WB.
  - IDLE → EXEC on `cmd_valid && cmd_ready`.
  - EXEC → WB unconditionally.
  - WB → IDLE unconditionally.
- `cmd_ready` = (state == IDLE). No acceptance in EXEC or WB.
- On accept:
  - `Upr_ALU` ← `cmd_op`.
  - `A` ← `regs[cmd_src_a]`, `B` ← `regs[cmd_src_b]`; values are read before any same-edge load is applied.
  - `dst` is latched.
- EXEC edge: `res_data` ← `Out_ALU`, `res_dst` ← latched dst.
- WB: `res_valid` = 1. At the closing edge, `regs[res_dst]` ← `res_data`.
- `Upr_ALU`, `A`, `B` hold their last values outside EXEC.
- The ALU result is used unmodified: no carry, no flags, no width change.
- Load port is honoured in every state.
  - Same-edge write conflict between a load and WB to the same address: WB wins, the load is dropped.
  - A load to a source register during EXEC/WB does not affect the in-flight result, because operands are already latched.
- `src_a == src_b == dst` is legal. The old value is read and the new value is written at WB.
- The stage has no checks on op code; all four codes are valid.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State = IDLE; all regs = 0.
  - `Upr_ALU` = 0, `A` = `B` = 0.
  - `res_valid` = 0, `res_data` = 0, `res_dst` = 0.
  - `cmd_ready` = 1 by decode, but commands and loads are ignored while `rst_n` is low.
- Latency, with the accepting edge as E0:
  - `Upr_ALU`/`A`/`B` are valid after E0.
  - `res_valid`/`res_data` are valid after E1, for exactly one cycle.
  - The register file is updated at E2, so `rd_data` shows the result after E2.
- `cmd_ready` returns high after E2, giving a maximum throughput of one command per 3 cycles.
- Reset asserted mid-operation aborts the command: no `res_valid` and no register write.
- `rd_data` is combinational: a load at edge E is visible after E.

## Structure
- Shared package `alu_pkg`:
  - op localparams `OP_ZERO`=0, `OP_ONE`=1, `OP_OR`=2, `OP_AND`=3;
  - FSM state encoding (IDLE/EXEC/WB);
  - default `WIDTH`/`RA_W`.
- Sub-module `alu_regfile`:
  - 2^RA_W × WIDTH storage;
  - three combinational read ports (a, b, debug);
  - two write requests with WB priority;
  - asynchronous clear.
- The top-level contains the FSM, operand/op registers and result capture.
- The ALU is instantiated beside this block, not inside it.

## Test plan
- Reset release: all `rd_addr` read 0; `cmd_ready`=1; `res_valid`=0; `Upr_ALU`=0; `A`=`B`=0.
- Load r1=0xF0F0_0000 and r2=0x0FF0_00FF, then issue op 2 (src 1,2 → dst 3):
  - `Upr_ALU`=2 after E0;
  - `res_valid` pulse after E1 with `res_data`=0xFFF0_00FF, `res_dst`=3;
  - r3=0xFFF0_00FF after E2.
- With the same operands:
  - op 3 → dst 0 gives r0=0x00F0_0000;
  - op 0 → dst 1 gives r1=0;
  - op 1 → dst 2 gives r2=0x0000_0001.
- Hold `cmd_valid`=1 for 9 cycles:
  - exactly 3 commands are accepted, spaced 3 cycles apart;
  - `cmd_ready` is low in EXEC/WB.
- Issue `ld_valid` to r3=0xDEAD_BEEF on the WB edge of a command writing r3 → r3 holds the ALU result.
- Issue a load of 0 to r1 during EXEC of op 2 (src 1) → result is unaffected.
- Assert `rst_n` low during EXEC → `res_valid` never pulses, dst remains 0, and state is IDLE after release.
